// File: rtl/rr_reg_arbiter_pkg.sv
// rr_reg_arbiter_pkg: shared constants, state encoding and clog2 helper
package rr_reg_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// rr_pick: round-robin winner search starting just after ptr
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      winner_o,
  output logic               any_o
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   idx;
  int                   sum;
  // rotate req so bit 0 is requester ptr+1, take the lowest set bit, map back modulo NUM_REQ
  always_comb begin
    dbl = {req_i, req_i};
    rot = NUM_REQ'(dbl >> (int'(ptr_i) + 1));
    any_o = |req_i;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) idx = i;
    sum = int'(ptr_i) + 1 + idx;
    sum = (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
    winner_o = PW'(sum);
  end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin shared register loader with per-owner lock bursts
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  localparam int PW = clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         lock_i,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [WIDTH-1:0]           data_out_o,
  output logic [PW-1:0]              owner_o,
  output logic                       out_valid_o,
  output logic                       locked_o
);
  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, win, sel;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d, any, load;
  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .winner_o(win),
    .any_o   (any)
  );
  assign sel  = (state_q == IDLE) ? win : owner_q;
  assign load = (state_q == IDLE) ? any : req_i[owner_q];
  // next state: a load captures the selected word; lock is only honoured for the winner/owner
  always_comb begin
    state_d = (state_q == IDLE) ? ((any && lock_i[win]) ? LOCKED : IDLE)
                                : (lock_i[owner_q] ? LOCKED : IDLE);
    data_d  = load ? data_in_i[int'(sel)*WIDTH +: WIDTH] : data_q;
    grant_d = load ? NUM_REQ'(1) << sel : '0;
    owner_d = load ? sel : owner_q;
    ptr_d   = load ? sel : ptr_q;
    valid_d = load;
  end
  // state and output registers; ptr resets to the last index so requester 0 goes first
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      owner_q <= '0;
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end
  assign grant_o     = grant_q;
  assign data_out_o  = data_q;
  assign owner_o     = owner_q;
  assign out_valid_o = valid_q;
  assign locked_o    = (state_q == LOCKED);
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: scoreboard bench for 4- and 3-requester arbiters
module tb_rr_reg_arbiter;
  typedef struct packed {
    logic       lk;
    logic [3:0] ptr;
    logic [7:0] data;
    logic [3:0] owner;
    logic [3:0] grant;
    logic       valid;
  } mdl_t;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  req_a = 0, lock_a = 0, grant_a;
  logic [31:0] din_a = 0;
  logic [7:0]  data_a, data_b;
  logic [1:0]  owner_a, owner_b;
  logic        valid_a, locked_a, valid_b, locked_b;
  logic [2:0]  req_b = 0, lock_b = 0, grant_b;
  logic [23:0] din_b = 24'h332211;
  int          total = 0, bad = 0;
  mdl_t        ma, mb, ea, eb;
  mdl_t        q_a[$], q_b[$];
  always #5 clk = ~clk;
  rr_reg_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut_a (
    .clk_i(clk), .reset_i(rst), .req_i(req_a), .lock_i(lock_a), .data_in_i(din_a),
    .grant_o(grant_a), .data_out_o(data_a), .owner_o(owner_a), .out_valid_o(valid_a), .locked_o(locked_a)
  );
  rr_reg_arbiter #(.WIDTH(8), .NUM_REQ(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .req_i(req_b), .lock_i(lock_b), .data_in_i(din_b),
    .grant_o(grant_b), .data_out_o(data_b), .owner_o(owner_b), .out_valid_o(valid_b), .locked_o(locked_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic mdl_t mreset(input int n);
    mdl_t r;
    r = '0;
    r.ptr = 4'(n - 1);
    return r;
  endfunction
  // reference: walk ptr+1, ptr+2, ... modulo n looking for a requester
  function automatic mdl_t step(input mdl_t m, input int n, input logic [3:0] rq,
                                input logic [3:0] lk, input logic [31:0] din);
    mdl_t r;
    int w;
    r = m;
    w = -1;
    r.grant = '0;
    r.valid = 1'b0;
    if (!m.lk) begin
      for (int k = 1; k <= n; k++)
        if (w < 0 && rq[(int'(m.ptr) + k) % n]) w = (int'(m.ptr) + k) % n;
      if (w >= 0 && lk[w]) r.lk = 1'b1;
    end else begin
      if (rq[m.owner]) w = int'(m.owner);
      if (!lk[m.owner]) r.lk = 1'b0;
    end
    if (w >= 0) begin
      r.data  = din[w*8 +: 8];
      r.grant = 4'(1) << w;
      r.owner = 4'(w);
      r.ptr   = 4'(w);
      r.valid = 1'b1;
    end
    return r;
  endfunction
  task automatic cyc(input logic [3:0] rq, input logic [3:0] lk, input logic [31:0] din,
                     input logic [2:0] rqb);
    @(negedge clk);
    req_a = rq;
    lock_a = lk;
    din_a = din;
    req_b = rqb;
    ma = step(ma, 4, rq, lk, din);
    mb = step(mb, 3, {1'b0, rqb}, {1'b0, lock_b}, {8'h0, din_b});
    q_a.push_back(ma);
    q_b.push_back(mb);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("a_grant", 32'(grant_a), 32'(ea.grant));
    chk("a_data", 32'(data_a), 32'(ea.data));
    chk("a_owner", 32'(owner_a), 32'(ea.owner));
    chk("a_valid", 32'(valid_a), 32'(ea.valid));
    chk("a_locked", 32'(locked_a), 32'(ea.lk));
    chk("b_grant", 32'(grant_b), 32'(eb.grant));
    chk("b_data", 32'(data_b), 32'(eb.data));
    chk("b_owner", 32'(owner_b), 32'(eb.owner));
    chk("b_valid", 32'(valid_b), 32'(eb.valid));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant_a), 0);
    chk({tag, "_data"}, 32'(data_a), 0);
    chk({tag, "_owner"}, 32'(owner_a), 0);
    chk({tag, "_valid"}, 32'(valid_a), 0);
    chk({tag, "_locked"}, 32'(locked_a), 0);
  endtask
  initial begin
    ma = mreset(4);
    mb = mreset(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk_zero("rst");
    // idle with no requests
    repeat (5) cyc(4'b0000, 4'b0000, 32'h0, 3'b000);
    // full rotation 0,1,2,3,0,...
    repeat (8) cyc(4'b1111, 4'b0000, 32'h44332211, 3'b000);
    chk("rot_last", 32'(grant_a), 32'h8);
    repeat (2) cyc(4'b1111, 4'b0000, 32'h44332211, 3'b000);
    chk("rot_g1", 32'(grant_a), 32'h2);
    // skip over idle requesters with wrap
    cyc(4'b1010, 4'b0000, 32'h44332211, 3'b000);
    chk("skip_g3", 32'(grant_a), 32'h8);
    cyc(4'b1010, 4'b0000, 32'h44332211, 3'b000);
    chk("skip_g1", 32'(grant_a), 32'h2);
    // lock burst owned by requester 1
    cyc(4'b0010, 4'b0010, 32'h4433A011, 3'b000);
    for (int i = 1; i < 4; i++) cyc(4'b1111, 4'b0010, {16'h4433, 8'(8'hA0 + i), 8'h11}, 3'b000);
    chk("burst_data", 32'(data_a), 32'hA3);
    chk("burst_locked", 32'(locked_a), 1);
    cyc(4'b1111, 4'b0000, 32'h4433A411, 3'b000);
    cyc(4'b1111, 4'b0000, 32'h44332211, 3'b000);
    chk("unlock_g2", 32'(grant_a), 32'h4);
    // owner stops requesting while still locked; others are ignored
    cyc(4'b0010, 4'b0010, 32'h4433B011, 3'b000);
    repeat (2) cyc(4'b1101, 4'b0010, 32'h44332211, 3'b000);
    chk("hold_data", 32'(data_a), 32'hB0);
    chk("hold_grant", 32'(grant_a), 0);
    // async reset while locked
    @(negedge clk);
    rst = 1;
    #1;
    chk_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    req_a = 0;
    lock_a = 0;
    rst = 0;
    ma = mreset(4);
    mb = mreset(3);
    // three-requester wrap
    repeat (5) cyc(4'b0000, 4'b0000, 32'h0, 3'b111);
    // random mix on both instances
    for (int i = 0; i < 40; i++)
      cyc(4'($urandom), 4'($urandom_range(0, 15)), $urandom, 3'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin arbiter that shares one parallel-load data register between num_req requesters.
- Each cycle, at most one requester wins and its data word is captured into the shared register.
- Optional lock lets the winner keep ownership for back-to-back loads (burst).
- Sits between multiple producers and a single downstream consumer of a registered word.

Parameters:
- width, 8, bits per data word and width of the shared register.
- num_req, 4, number of requesters (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  num_req  per-requester load request, level.
- lock  input  num_req  per-requester ownership hold, sampled only for the current winner/owner.
- data_in  input  num_req*width  requester words, requester i at bits [i*width +: width].
- grant  output  num_req  registered one-hot; pulses in the cycle after a load is accepted.
- data_out  output  width  shared register contents.
- owner  output  clog2(num_req)  index of the last requester loaded.
- out_valid  output  1  high for one cycle when data_out has just been updated.
- locked  output  1  high while in LOCKED state.

Behaviour:
- Reset (async, immediate) drives:
  - data_out=0, grant=0, owner=0, out_valid=0, locked=0.
  - state=IDLE.
  - priority pointer ptr=num_req-1, so requester 0 has first priority.
- Latency: req sampled on edge N; data_out, grant, owner and out_valid update on edge N (visible in cycle N+1). One load per cycle maximum.
- IDLE:
  - If req==0: grant=0, out_valid=0, data_out/owner hold.
  - Else winner = first set req bit searching ptr+1, ptr+2, … with wrap-around modulo num_req.
  - On the edge: data_out<=winner slice, grant<=onehot(winner), owner<=winner, out_valid<=1, ptr<=winner.
  - If lock[winner]=1 in the same cycle: next state LOCKED, locked<=1.
- LOCKED:
  - Only requester owner is considered; all other req bits are ignored (no grant, no starvation accounting).
  - If req[owner]=1: load its word, grant pulse, out_valid=1.
  - If req[owner]=0: no load, grant=0, out_valid=0.
  - If lock[owner]=0 in a cycle: next state IDLE, locked<=0. A load in that same cycle still occurs if req[owner]=1.
  - ptr stays at owner, so after unlock the search restarts at owner+1.
- Fairness: with all req held high and no locks, grants rotate 0,1,2,…,num_req-1,0 with one grant per cycle.
- Simultaneous req and lock from a non-winner: that lock is ignored.
- Reset asserted mid-LOCKED: immediate return to IDLE; data cleared; ptr reinitialised.
- grant is always one-hot or zero; out_valid == |grant at all times.
- Synthesisable, no latches; num_req not a power of two must still wrap correctly.

Decomposition:
- Shared package: clog2 constant function; state encoding constants IDLE=1'b0, LOCKED=1'b1.
- Sub-module rr_pick (combinational): inputs req, ptr; outputs winner index and any_req.
  - Implement with a double-width rotate-and-priority-encode.
- Top level holds the FSM, ptr, and the data/grant/owner registers.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> data_out=0, grant=0, out_valid=0 throughout; assert reset mid-run -> all outputs 0 immediately, without waiting for clk.
2. req=4'b1111, data_in words 0x11/0x22/0x33/0x44 for req0..req3, lock=0, 8 cycles -> grant sequence 0001,0010,0100,1000,0001…; data_out 0x11,0x22,0x33,0x44,0x11….
3. After a grant to req1, drive req=4'b1010 -> next grant is req3, then req1 (wrap past 0 and 2).
4. Lock burst: req1 wins with lock[1]=1; hold req=4'b1111, lock=4'b0010 for 4 cycles with data_in1 = 0xA0..0xA3 -> four consecutive grants 0010, data_out follows 0xA0..0xA3, locked=1. Drop lock[1] -> next grant goes to req2.
5. In LOCKED, drop req[1] for 2 cycles while lock[1]=1 -> grant=0, out_valid=0, data_out holds, locked stays 1, req0/2/3 get no grants.
6. num_req=3, req=3'b111 -> grants rotate 0,1,2,0; owner never reaches 3.
